// File: rtl/mawg_hop_scheduler.sv
// mawg_hop_scheduler: table-driven frequency-hop and wave-sequence scheduler
module mawg_hop_scheduler #(
   parameter int IDX_W   = 3,
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_addr,
   input  logic [31:0]        wr_freq,
   input  logic [1:0]         wr_wave,
   input  logic [DWELL_W-1:0] wr_dwell,
   input  logic [IDX_W-1:0]   last_idx,
   input  logic               loop_en,
   input  logic               start,
   input  logic               abort,
   input  logic [31:0]        idle_freq,
   output logic [31:0]        freq_ctrl,
   output logic [1:0]         wave_sel,
   output logic [IDX_W-1:0]   cur_idx,
   output logic               busy,
   output logic               hop,
   output logic               done
);
   localparam int N = 2 ** IDX_W;
   typedef enum logic {IDLE, RUN} state_t;
   state_t             state_q;
   logic [31:0]        freq_tab [N];
   logic [1:0]         wave_tab [N];
   logic [DWELL_W-1:0] dwell_tab [N];
   logic [31:0]        freq_q;
   logic [1:0]         wave_q;
   logic [IDX_W-1:0]   cur_idx_q, last_q, ld_idx_d;
   logic [DWELL_W-1:0] cnt_q, ld_cnt_d;
   logic               loop_q, busy_q, hop_q, done_q, ld_d;
   assign freq_ctrl = freq_q;
   assign wave_sel  = wave_q;
   assign cur_idx   = cur_idx_q;
   assign busy      = busy_q;
   assign hop       = hop_q;
   assign done      = done_q;
   // pick the entry to load next and whether a load happens this edge; a zero dwell holds for one cycle
   always_comb begin
      ld_idx_d = (state_q == IDLE || cur_idx_q == last_q) ? '0 : cur_idx_q + 1'b1;
      ld_cnt_d = (dwell_tab[ld_idx_d] == '0) ? '0 : dwell_tab[ld_idx_d] - 1'b1;
      ld_d     = (state_q == IDLE) ? start : (cnt_q == '0 && (cur_idx_q != last_q || loop_q));
   end
   // table storage, unreset; reads above see the pre-write contents on the same edge
   always_ff @(posedge clk) begin
      if (wr_en) begin
         freq_tab[wr_addr]  <= wr_freq;
         wave_tab[wr_addr]  <= wr_wave;
         dwell_tab[wr_addr] <= wr_dwell;
      end
   end
   // sequencer: abort outranks everything but reset; last/loop are frozen at start
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         freq_q    <= '0;
         wave_q    <= '0;
         cur_idx_q <= '0;
         last_q    <= '0;
         loop_q    <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         hop_q     <= 1'b0;
         done_q    <= 1'b0;
      end else if (abort) begin
         state_q   <= IDLE;
         freq_q    <= idle_freq;
         wave_q    <= '0;
         cur_idx_q <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         hop_q     <= 1'b0;
         done_q    <= 1'b0;
      end else if (ld_d) begin
         if (state_q == IDLE) begin
            last_q <= last_idx;
            loop_q <= loop_en;
         end
         state_q   <= RUN;
         freq_q    <= freq_tab[ld_idx_d];
         wave_q    <= wave_tab[ld_idx_d];
         cur_idx_q <= ld_idx_d;
         cnt_q     <= ld_cnt_d;
         busy_q    <= 1'b1;
         hop_q     <= 1'b1;
         done_q    <= 1'b0;
      end else if (state_q == RUN && cnt_q != '0) begin
         cnt_q  <= cnt_q - 1'b1;
         hop_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q    <= (state_q == RUN);
         state_q   <= IDLE;
         freq_q    <= idle_freq;
         wave_q    <= '0;
         cur_idx_q <= '0;
         busy_q    <= 1'b0;
         hop_q     <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mawg_hop_scheduler.sv
// tb_mawg_hop_scheduler: directed plan scenarios plus random traffic against a behavioural model
module tb_mawg_hop_scheduler;
   logic        clk = 0;
   logic        rst = 1;
   logic        wr_en = 0;
   logic [2:0]  wr_addr = 0;
   logic [31:0] wr_freq = 0;
   logic [1:0]  wr_wave = 0;
   logic [23:0] wr_dwell = 0;
   logic [2:0]  last_idx = 0;
   logic        loop_en = 0;
   logic        start = 0;
   logic        abort = 0;
   logic [31:0] idle_freq = 32'hAAAA;
   logic [31:0] freq_ctrl;
   logic [1:0]  wave_sel;
   logic [2:0]  cur_idx;
   logic        busy, hop, done;
   int checks = 0;
   int errors = 0;

   mawg_hop_scheduler dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq),
      .wr_wave(wr_wave), .wr_dwell(wr_dwell), .last_idx(last_idx), .loop_en(loop_en),
      .start(start), .abort(abort), .idle_freq(idle_freq), .freq_ctrl(freq_ctrl),
      .wave_sel(wave_sel), .cur_idx(cur_idx), .busy(busy), .hop(hop), .done(done)
   );

   always #5 clk = ~clk;

   // behavioural model: a sequence walks entries, each visible for max(dwell,1) cycles
   logic [31:0] m_tf [8];
   logic [1:0]  m_tw [8];
   int          m_td [8];
   bit          m_run = 0, m_loop = 0;
   int          m_idx = 0, m_rem = 0, m_last = 0;
   logic [31:0] e_freq = 0;
   logic [1:0]  e_wave = 0;
   bit          e_hop = 0, e_done = 0;

   task automatic apply(input int i);
      e_freq = m_tf[i];
      e_wave = m_tw[i];
      m_rem  = (m_td[i] == 0) ? 1 : m_td[i];
      m_idx  = i;
      e_hop  = 1;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_run = 0; e_freq = 0; e_wave = 0; m_idx = 0; e_hop = 0; e_done = 0; m_rem = 0;
      end else if (abort) begin
         m_run = 0; e_freq = idle_freq; e_wave = 0; m_idx = 0; e_hop = 0; e_done = 0;
      end else if (!m_run) begin
         e_done = 0;
         if (start) begin
            m_last = int'(last_idx);
            m_loop = loop_en;
            m_run  = 1;
            apply(0);
         end else begin
            e_freq = idle_freq; e_wave = 0; e_hop = 0;
         end
      end else begin
         e_hop = 0;
         e_done = 0;
         m_rem--;
         if (m_rem == 0) begin
            if (m_idx < m_last) apply(m_idx + 1);
            else if (m_loop) apply(0);
            else begin
               m_run = 0; e_done = 1; e_freq = idle_freq; e_wave = 0; m_idx = 0;
            end
         end
      end
      if (wr_en) begin
         m_tf[wr_addr] = wr_freq;
         m_tw[wr_addr] = wr_wave;
         m_td[wr_addr] = int'(wr_dwell);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // advance to the next falling edge and compare every output against the model
   task automatic cyc();
      @(negedge clk);
      chk("model", {26'd0, freq_ctrl, wave_sel, cur_idx, busy, hop, done},
          {26'd0, e_freq, e_wave, 3'(m_idx), m_run, e_hop, e_done});
   endtask

   task automatic wr(input int a, input logic [31:0] f, input logic [1:0] w, input logic [23:0] d);
      wr_en = 1; wr_addr = 3'(a); wr_freq = f; wr_wave = w; wr_dwell = d;
      cyc();
      wr_en = 0;
   endtask

   logic [31:0] exp_f [6];
   bit          exp_h [6];

   initial begin
      cyc(); cyc();
      chk("reset_freq", {32'd0, freq_ctrl}, 64'd0);
      chk("reset_flags", {59'd0, cur_idx, busy, hop}, 64'd0);
      rst = 0;
      wr(0, 32'h1000, 2'd0, 24'd3);
      wr(1, 32'h2000, 2'd1, 24'd1);
      wr(2, 32'h3000, 2'd2, 24'd0);
      for (int i = 3; i < 8; i++) wr(i, 32'h100 * i, 2'(i), 24'd2);
      chk("idle_freq", {32'd0, freq_ctrl}, 64'hAAAA);
      // basic sequence, last_idx altered mid-run with no effect
      last_idx = 2; loop_en = 0; start = 1;
      cyc(); start = 0; last_idx = 0;
      chk("s1_e0_hop", {32'd0, freq_ctrl}, 64'h1000);
      chk("s1_hop0", {62'd0, hop, busy}, 64'd3);
      cyc(); cyc();
      chk("s1_e0_last", {32'd0, freq_ctrl}, 64'h1000);
      wr_en = 1; wr_addr = 1; wr_freq = 32'h5555; wr_wave = 1; wr_dwell = 1;
      cyc(); wr_en = 0;
      chk("s1_rbw", {32'd0, freq_ctrl}, 64'h2000);
      chk("s1_wave1", {62'd0, wave_sel}, 64'd1);
      cyc();
      chk("s1_e2", {32'd0, freq_ctrl}, 64'h3000);
      chk("s1_hop2", {63'd0, hop}, 64'd1);
      cyc();
      chk("s1_done", {32'd0, freq_ctrl}, 64'hAAAA);
      chk("s1_done_flags", {62'd0, done, busy}, 64'd2);
      cyc();
      chk("s1_done_once", {63'd0, done}, 64'd0);
      // loop run showing the rewritten entry 1 and the 2->0 hop
      last_idx = 2; loop_en = 1; start = 1;
      exp_f = '{32'h1000, 32'h1000, 32'h1000, 32'h5555, 32'h3000, 32'h1000};
      exp_h = '{1, 0, 0, 1, 1, 1};
      for (int i = 0; i < 6; i++) begin
         cyc();
         start = (i == 1);
         chk("loop_f", {32'd0, freq_ctrl}, {32'd0, exp_f[i]});
         chk("loop_hop", {63'd0, hop}, {63'd0, exp_h[i]});
      end
      start = 0;
      repeat (7) cyc();
      abort = 1;
      cyc(); abort = 0;
      chk("abort", {31'd0, busy, freq_ctrl}, 64'hAAAA);
      cyc();
      chk("abort_no_done", {63'd0, done}, 64'd0);
      start = 1; abort = 1;
      cyc(); start = 0; abort = 0;
      chk("start_abort_idle", {63'd0, busy}, 64'd0);
      loop_en = 0; start = 1;
      cyc(); start = 0;
      cyc();
      rst = 1;
      cyc(); rst = 0;
      chk("rst_mid", {31'd0, busy, freq_ctrl}, 64'd0);
      cyc();
      chk("rst_then_idle", {32'd0, freq_ctrl}, 64'hAAAA);
      // random traffic; every cycle is checked against the model
      for (int i = 0; i < 4000; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         abort    = ($urandom_range(0, 59) == 0);
         start    = ($urandom_range(0, 4) == 0);
         wr_en    = ($urandom_range(0, 5) == 0);
         wr_addr  = 3'($urandom);
         wr_freq  = $urandom;
         wr_wave  = 2'($urandom);
         wr_dwell = 24'($urandom_range(0, 4));
         last_idx = 3'($urandom);
         loop_en  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) idle_freq = $urandom;
         cyc();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mawg_hop_scheduler.md
Name: mawg_hop_scheduler

Overview:
- Table-driven frequency-hop and wave-sequence scheduler that drives the wave generator's freq_ctrl and wave_sel.
- Holds a small table of {freq, wave, dwell} entries. On start it steps through entries 0..last_idx, holding each for its dwell time. It stops or loops at the end, then falls back to idle_freq.
- Sits between the host configuration registers and the wave generator / FM chain. All other generator inputs bypass this block.

Parameters:
- IDX_W, 3, table index width; the table has 2**IDX_W entries.
- DWELL_W, 24, dwell counter width in clk cycles.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  IDX_W  table entry to write.
- wr_freq  in  32  phase-increment word for the entry.
- wr_wave  in  2  wave select for the entry.
- wr_dwell  in  DWELL_W  hold time in cycles; 0 is treated as 1.
- last_idx  in  IDX_W  final entry of the sequence; sampled on accepted start.
- loop_en  in  1  1 = wrap to entry 0 after last_idx; sampled on accepted start.
- start  in  1  begin sequence; honoured only in IDLE.
- abort  in  1  stop sequence immediately.
- idle_freq  in  32  freq_ctrl value while idle.
- freq_ctrl  out  32  registered, to the wave generator.
- wave_sel  out  2  registered, to the wave generator.
- cur_idx  out  IDX_W  entry currently applied.
- busy  out  1  high in RUN.
- hop  out  1  one-cycle pulse in the first cycle of each newly applied entry.
- done  out  1  one-cycle pulse on normal (non-loop) completion.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; freq_ctrl=0, wave_sel=0, cur_idx=0, busy=0, hop=0, done=0; dwell counter=0.
  - Table contents are not reset; software must write entries before use.
- States: IDLE, RUN. All outputs are registered.
- IDLE:
  - freq_ctrl<=idle_freq every cycle (one-cycle latency); wave_sel<=0.
  - start=1 and abort=0 at edge N: at edge N, freq_ctrl/wave_sel<=table[0], cur_idx<=0, cnt<=max(dwell0,1)-1, hop<=1, busy<=1, last_idx/loop_en latched, state<=RUN.
  - The outputs therefore show entry 0 in cycle N+1.
- RUN, each edge:
  - cnt!=0: cnt<=cnt-1, outputs hold.
  - cnt==0 and cur_idx!=latched last: load entry cur_idx+1 exactly as above (hop pulse).
  - cnt==0, cur_idx==last, loop=1: load entry 0 (hop pulse).
  - cnt==0, cur_idx==last, loop=0: state<=IDLE, busy<=0, done<=1, freq_ctrl<=idle_freq, wave_sel<=0, cur_idx<=0.
- Dwell timing: each entry is visible on freq_ctrl for exactly max(dwell,1) consecutive cycles. Hop boundaries have no gap cycles.
- Index wrap: cur_idx+1 never exceeds last because last is latched. last_idx=2**IDX_W-1 is legal.
- abort:
  - Highest priority after rst.
  - In RUN: next edge → IDLE, busy=0, hop=0, done=0, outputs<=idle_freq/0, cur_idx<=0.
  - In IDLE with start in the same cycle: start is ignored.
- start while busy: ignored; no restart.
- Table writes:
  - Allowed in any state and take effect at the edge.
  - A load in the same cycle as a write to that entry reads the old value (read-before-write).
  - Writes to entries already applied do not alter current outputs.
- Live vs latched inputs: changing last_idx/loop_en during RUN has no effect. idle_freq is always live.
- rst mid-RUN: immediate return to reset values at that edge; no done pulse.
- Arithmetic: cnt is unsigned DWELL_W; no overflow is possible because it only decrements from a loaded value.

Test Plan:
- Table {0:f=0x1000,w=0,d=3; 1:f=0x2000,w=1,d=1; 2:f=0x3000,w=2,d=0}, last=2, loop=0, idle_freq=0xAAAA, start pulse at cycle 10 → freq_ctrl: 0x1000 in cycles 11-13, 0x2000 in cycle 14, 0x3000 in cycle 15, 0xAAAA from 16. hop pulses at 11, 14, 15; done pulse at 16; busy high 11-15.
- Same table with loop=1 → sequence repeats with period 5 cycles; done never asserts; hop pulses every cycle where the entry changes, including 2→0.
- Abort asserted in cycle 12 of the first scenario → freq_ctrl=0xAAAA and busy=0 from cycle 13; no done pulse; a second start at 20 restarts at entry 0 in cycle 21.
- Write entry 1 to f=0x5555 in cycle 13 (same edge that loads entry 1) → cycle 14 shows 0x2000. Rerun → 0x5555 appears.
- start and abort together in IDLE → stays IDLE. start while busy → ignored, timing unchanged. rst in cycle 12 → freq_ctrl=0 in cycle 13, then 0xAAAA from cycle 14.
- last_idx changed 2→0 during RUN → full 3-entry sequence still executes.
